// File: rtl/vector_result_serializer.sv
// vector_result_serializer
// Streams one captured 3-lane vector (x, y, z) as bytes over an 8-bit
// valid/ready link. Lanes go out in the order x, y, z, most significant byte
// first. out_last marks the final byte of each frame.
// Optional feature macro: VEC_SERIALIZER_CHECKSUM_EN appends a trailing byte
// that is the XOR of all data bytes in the frame.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   vector input handshake
//   in_x/in_y/in_z      lane words, passed through bit-exact
//   out_data/out_valid  byte output
//   out_ready           downstream accepts the current byte
//   out_last            current byte ends the frame
//   busy                a frame is in progress
module vector_result_serializer #(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned NUM_LANES = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_x,
  input  logic [WORD_W-1:0] in_y,
  input  logic [WORD_W-1:0] in_z,
  output logic              in_ready,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy
);

  localparam int unsigned VEC_W  = NUM_LANES * WORD_W;
  localparam int unsigned NBYTES = VEC_W / 8;
  localparam int unsigned CNT_W  = $clog2(NBYTES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBYTES - 1);

`ifdef VEC_SERIALIZER_CHECKSUM_EN
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_CSUM} state_e;
`else
  typedef enum logic {S_IDLE, S_SEND} state_e;
`endif

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [VEC_W-1:0]   shift_q, shift_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic               in_ready_q;
  logic               busy_q;
  logic [7:0]         top_byte;
`ifdef VEC_SERIALIZER_CHECKSUM_EN
  logic [7:0]         csum_q, csum_d;
`endif

  assign top_byte = shift_q[VEC_W-1 -: 8];

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
`ifdef VEC_SERIALIZER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      in_ready_q  <= (state_d == S_IDLE);
      busy_q      <= (state_d != S_IDLE);
`ifdef VEC_SERIALIZER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
`ifdef VEC_SERIALIZER_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        // in_ready is high exactly while in IDLE
        if (in_valid) begin
          shift_d = VEC_W'({in_x, in_y, in_z});
          cnt_d   = '0;
          state_d = S_SEND;
`ifdef VEC_SERIALIZER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      S_SEND: begin
        if (out_ready) begin
          shift_d = {shift_q[VEC_W-9:0], 8'h00};
          cnt_d   = cnt_q + CNT_W'(1);
`ifdef VEC_SERIALIZER_CHECKSUM_EN
          csum_d  = csum_q ^ top_byte;
          if (cnt_q == LAST_CNT) begin
            // Register is fully shifted out; park the checksum in the top byte
            shift_d = {csum_q ^ top_byte, (VEC_W-8)'(0)};
            state_d = S_CSUM;
          end
`else
          if (cnt_q == LAST_CNT) begin
            state_d = S_IDLE;
          end
`endif
        end
      end
`ifdef VEC_SERIALIZER_CHECKSUM_EN
      S_CSUM: begin
        if (out_ready) begin
          shift_d = '0;
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    out_valid_d = (state_d != S_IDLE);
`ifdef VEC_SERIALIZER_CHECKSUM_EN
    out_last_d  = (state_d == S_CSUM);
`else
    out_last_d  = (state_d == S_SEND) && (cnt_d == LAST_CNT);
`endif
  end

  assign out_data  = top_byte;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign in_ready  = in_ready_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_vector_result_serializer.sv
// Testbench for vector_result_serializer: directed steps with a byte
// scoreboard filled when a vector is accepted and drained as bytes transfer.
module tb_vector_result_serializer;

  localparam int unsigned NBYTES = 12;
`ifdef VEC_SERIALIZER_CHECKSUM_EN
  localparam int unsigned NFRAME = NBYTES + 1;
`else
  localparam int unsigned NFRAME = NBYTES;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_x, in_y, in_z;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;

  exp_t        exp_q[$];
  int          checks;
  int          failures;
  logic        prev_stall;
  logic [7:0]  prev_data;
  logic        prev_last;
  logic        rand_ready;

  vector_result_serializer #(.WORD_W(32), .NUM_LANES(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_z      (in_z),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected frame: x, y, z MSB byte first, then optional XOR checksum
  task automatic push_frame(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    logic [95:0] v;
    logic [7:0]  b;
    logic [7:0]  cs;
    exp_t        e;
    v  = {x, y, z};
    cs = 8'h00;
    for (int i = 0; i < int'(NBYTES); i++) begin
      b      = v[95 - 8*i -: 8];
      cs     = cs ^ b;
      e.data = b;
      e.last = (i == int'(NFRAME) - 1);
      exp_q.push_back(e);
    end
`ifdef VEC_SERIALIZER_CHECKSUM_EN
    e.data = cs;
    e.last = 1'b1;
    exp_q.push_back(e);
`endif
  endtask

  // Check the current cycle (outputs sampled 1 time unit after the edge), then advance
  task automatic tick();
    exp_t e;
    if (prev_stall) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", 32'(out_data), 32'(prev_data));
      chk("stall_last", 32'(out_last), 32'(prev_last));
    end
    if (out_valid && out_ready) begin
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("byte_data", 32'(out_data), 32'(e.data));
        chk("byte_last", 32'(out_last), 32'(e.last));
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    prev_last  = out_last;
    @(posedge clk);
    #1;
  endtask

  task automatic send_vector(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    int n;
    n        = 0;
    in_x     = x;
    in_y     = y;
    in_z     = z;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    chk("accept_ready", 32'(in_ready), 32'd1);
    push_frame(x, y, z);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < max_cycles) begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    out_ready = 1'b1;
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_idle", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int cnt;
    checks     = 0;
    failures   = 0;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    prev_last  = 1'b0;
    rand_ready = 1'b0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_x       = '0;
    in_y       = '0;
    in_z       = '0;
    out_ready  = 1'b0;
    #22 rst_n  = 1'b1;
    @(posedge clk);
    #1;

    // Reset values
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Spurious out_ready while idle
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk("idle_out_valid", 32'(out_valid), 32'd0);
      chk("idle_out_data", 32'(out_data), 32'h00);
      chk("idle_busy", 32'(busy), 32'd0);
      tick();
    end

    // Basic frame at full rate: one byte per cycle starting the cycle after capture
    send_vector(32'h0001_0000, 32'hFFFF_0000, 32'h1234_5678);
    chk("basic_first_valid", 32'(out_valid), 32'd1);
    chk("basic_first_byte", 32'(out_data), 32'h00);
    for (int i = 0; i < int'(NFRAME); i++) begin
      chk("basic_in_ready", 32'(in_ready), 32'd0);
      chk("basic_busy", 32'(busy), 32'd1);
      tick();
    end
    chk("basic_done_empty", 32'(exp_q.size()), 32'd0);
    chk("basic_done_valid", 32'(out_valid), 32'd0);
    chk("basic_done_ready", 32'(in_ready), 32'd1);
    chk("basic_done_busy", 32'(busy), 32'd0);

    // Random back-pressure
    rand_ready = 1'b1;
    out_ready  = 1'b0;
    send_vector(32'h0001_0000, 32'hFFFF_0000, 32'h1234_5678);
    drain(500);
    rand_ready = 1'b0;

    // in_valid pulse during a frame must not capture
    out_ready = 1'b1;
    send_vector(32'h0001_0000, 32'hFFFF_0000, 32'h1234_5678);
    for (int i = 0; i < 4; i++) tick();
    in_x     = 32'hDEAD_BEEF;
    in_valid = 1'b1;
    chk("busy_in_ready", 32'(in_ready), 32'd0);
    tick();
    in_valid = 1'b0;
    in_x     = '0;
    drain(100);
    for (int i = 0; i < 3; i++) begin
      chk("post_ignore_busy", 32'(busy), 32'd0);
      tick();
    end

    // Back-to-back: in_valid held across two vectors
    out_ready = 1'b1;
    send_vector(32'h0001_0000, 32'hFFFF_0000, 32'h1234_5678);
    in_valid = 1'b1;
    in_x     = 32'h7FFF_FFFF;
    in_y     = 32'h8000_0000;
    in_z     = 32'h0000_0001;
    cnt      = 0;
    while (!in_ready && cnt < 100) begin
      tick();
      cnt++;
    end
    chk("b2b_gap", 32'(cnt), 32'(NFRAME));
    chk("b2b_gap_valid", 32'(out_valid), 32'd0);
    push_frame(32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0001);
    tick();
    in_valid = 1'b0;
    chk("b2b_second_start", 32'(out_data), 32'h7F);
    drain(100);

    // Reset in the middle of a frame
    send_vector(32'h0001_0000, 32'hFFFF_0000, 32'h1234_5678);
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_data", 32'(out_data), 32'h00);
    chk("midrst_out_last", 32'(out_last), 32'd0);
    exp_q.delete();
    prev_stall = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_vector(32'hA1B2_C3D4, 32'h0102_0304, 32'hF0E0_D0C0);
    chk("postrst_first_byte", 32'(out_data), 32'hA1);
    drain(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
